// File: rtl/shift_arb.sv
// Two-requester round-robin arbiter in front of one shared 32-bit shifter.
// The winning operation is shifted and registered; out_valid/out_ready drain it.
module shift_arb #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_d,
  input  logic [4:0]  req0_sa,
  input  logic        req0_right,
  input  logic        req0_arith,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_d,
  input  logic [4:0]  req1_sa,
  input  logic        req1_right,
  input  logic        req1_arith,
  output logic        req1_ready,
  output logic        out_valid,
  output logic [31:0] out_sh,
  output logic        out_id,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        ptr_r;
  logic        can_accept_s;
  logic        gnt0_s;
  logic        gnt1_s;
  logic [31:0] op_d_s;
  logic [4:0]  op_sa_s;
  logic        op_right_s;
  logic        op_arith_s;
  logic [31:0] sh_s;
  logic [31:0] out_sh_r;
  logic        out_id_r;

  // arith only matters for right shifts; left shifts fall through to default
  function automatic logic [31:0] shift_fn(input logic [31:0] d, input logic [4:0] sa,
                                           input logic right, input logic arith);
    logic [31:0] res;
    case ({right, arith})
      2'b10:   res = d >> sa;
      2'b11:   res = 32'($signed(d) >>> sa);
      default: res = d << sa;
    endcase
    return res;
  endfunction

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state: any grant refills, an unrefilled drain empties
  always_comb begin
    state_nxt_s = state_r;
    if (gnt0_s || gnt1_s) begin
      state_nxt_s = FULL;
    end else if ((state_r == FULL) && out_ready) begin
      state_nxt_s = EMPTY;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // grant/ready outputs; rst gates readies so nothing is accepted during reset
  always_comb begin
    can_accept_s = !rst && ((state_r == EMPTY) || out_ready);
    gnt0_s       = 1'b0;
    gnt1_s       = 1'b0;
    if (can_accept_s) begin
      gnt0_s = req0_valid && (!req1_valid || (ptr_r == 1'b0));
      gnt1_s = req1_valid && (!req0_valid || (ptr_r == 1'b1));
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
    req0_ready = gnt0_s;
    req1_ready = gnt1_s;
  end

  // operand mux feeding the single shifter
  always_comb begin
    if (gnt1_s) begin
      op_d_s     = req1_d;
      op_sa_s    = req1_sa;
      op_right_s = req1_right;
      op_arith_s = req1_arith;
    end else begin
      op_d_s     = req0_d;
      op_sa_s    = req0_sa;
      op_right_s = req0_right;
      op_arith_s = req0_arith;
    end
    sh_s = shift_fn(op_d_s, op_sa_s, op_right_s, op_arith_s);
  end

  // result register and round-robin pointer (points at the loser after each grant)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sh_r <= 32'h0000_0000;
      out_id_r <= 1'b0;
      ptr_r    <= RR_INIT;
    end else if (gnt0_s || gnt1_s) begin
      out_sh_r <= sh_s;
      out_id_r <= gnt1_s;
      ptr_r    <= gnt0_s;
    end else begin
      out_sh_r <= out_sh_r;
      out_id_r <= out_id_r;
      ptr_r    <= ptr_r;
    end
  end

  assign out_valid = (state_r == FULL);
  assign busy      = (state_r == FULL);
  assign out_sh    = out_sh_r;
  assign out_id    = out_id_r;

endmodule

// File: tb/tb_shift_arb.sv
// Scoreboard bench for shift_arb: the driver pushes hand-computed results on each
// expected grant, a monitor pops and compares on every output handshake.
module tb_shift_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_right, req0_arith, req0_ready;
  logic [31:0] req0_d;
  logic [4:0]  req0_sa;
  logic        req1_valid, req1_right, req1_arith, req1_ready;
  logic [31:0] req1_d;
  logic [4:0]  req1_sa;
  logic        out_valid, out_id, out_ready, busy;
  logic [31:0] out_sh;

  int vectors = 0;
  int miscompares = 0;
  logic [32:0] sb_q[$];

  shift_arb #(.RR_INIT(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_d(req0_d), .req0_sa(req0_sa),
    .req0_right(req0_right), .req0_arith(req0_arith), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_d(req1_d), .req1_sa(req1_sa),
    .req1_right(req1_right), .req1_arith(req1_arith), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_sh(out_sh), .out_id(out_id),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+2: drive one cycle, check readies, push the expected result,
  // then return at the next posedge+2.
  task automatic cyc(input logic v0, input logic [31:0] d0, input logic [4:0] sa0,
                     input logic r0, input logic a0,
                     input logic v1, input logic [31:0] d1, input logic [4:0] sa1,
                     input logic r1, input logic a1,
                     input logic ordy, input logic e0, input logic e1,
                     input logic [31:0] esh);
    req0_valid = v0; req0_d = d0; req0_sa = sa0; req0_right = r0; req0_arith = a0;
    req1_valid = v1; req1_d = d1; req1_sa = sa1; req1_right = r1; req1_arith = a1;
    out_ready = ordy;
    #1;
    chk("ready", {31'h0, req1_ready, req0_ready}, {31'h0, e1, e0});
    if (e0 || e1) sb_q.push_back({e1, esh});
    @(posedge clk);
    #2;
  endtask

  // monitor: a handshake at the coming edge retires the oldest expected result
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", {out_id, out_sh}, 33'h1_DEAD_BEEF);
      end else begin
        chk("result", {out_id, out_sh}, sb_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req0_d = 32'h0000_0001; req0_sa = 5'd1; req0_right = 1'b0; req0_arith = 1'b0;
    req1_valid = 1'b1; req1_d = 32'h0000_0010; req1_sa = 5'd1; req1_right = 1'b1; req1_arith = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    chk("rst_ready", {31'h0, req1_ready, req0_ready}, 33'h0);
    chk("rst_valid_busy", {31'h0, busy, out_valid}, 33'h0);
    chk("rst_out", {out_id, out_sh}, 33'h0);
    rst = 1'b0;

    // both valid: grants alternate 0,1,0,1 from RR_INIT=0
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 32'h0000_0001, 5'd1, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 5'd1, 1'b1, 1'b0,
          1'b1, (i % 2) == 0, (i % 2) == 1, ((i % 2) == 0) ? 32'h0000_0002 : 32'h0000_0008);
    // req0 arithmetic right of a negative operand
    cyc(1'b1, 32'h8000_0001, 5'd4, 1'b1, 1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0,
        1'b1, 1'b1, 1'b0, 32'hF800_0000);
    cyc(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("drained_to_empty", {32'h0, out_valid}, 33'h0);
    // sa=31 boundaries from requester 1
    cyc(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_00FF, 5'd31, 1'b0, 1'b0,
        1'b1, 1'b0, 1'b1, 32'h8000_0000);
    cyc(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 5'd31, 1'b1, 1'b0,
        1'b1, 1'b0, 1'b1, 32'h0000_0001);
    // sa=0 in all three modes
    cyc(1'b1, 32'hA5A5_A5A5, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0,
        1'b1, 1'b1, 1'b0, 32'hA5A5_A5A5);
    cyc(1'b1, 32'hA5A5_A5A5, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0,
        1'b1, 1'b1, 1'b0, 32'hA5A5_A5A5);
    cyc(1'b1, 32'hA5A5_A5A5, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0,
        1'b1, 1'b1, 1'b0, 32'hA5A5_A5A5);
    // sign fill at sa=31, and arith ignored on a left shift
    cyc(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 5'd31, 1'b1, 1'b1,
        1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    cyc(1'b1, 32'h0000_0001, 5'd3, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0,
        1'b1, 1'b1, 1'b0, 32'h0000_0008);
    // stall: FULL with out_ready=0 while both requesters wait
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 32'h0000_0003, 5'd2, 1'b0, 1'b0, 1'b1, 32'hFFFF_0000, 5'd16, 1'b1, 1'b1,
          1'b0, 1'b0, 1'b0, 32'h0);
      chk("hold_out", {out_id, out_sh}, {1'b0, 32'h0000_0008});
    end
    // drain and refill in the same cycle; pointer was left at 1
    cyc(1'b1, 32'h0000_0003, 5'd2, 1'b0, 1'b0, 1'b1, 32'hFFFF_0000, 5'd16, 1'b1, 1'b1,
        1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    cyc(1'b1, 32'h0000_0003, 5'd2, 1'b0, 1'b0, 1'b1, 32'hFFFF_0000, 5'd16, 1'b1, 1'b1,
        1'b1, 1'b1, 1'b0, 32'h0000_000C);
    cyc(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    // asynchronous reset mid-cycle while FULL (pointer currently 1)
    req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
    chk("full_before_rst", {32'h0, out_valid}, 33'h1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid_busy", {31'h0, busy, out_valid}, 33'h0);
    chk("async_rst_out", {out_id, out_sh}, 33'h0);
    chk("async_rst_ready", {31'h0, req1_ready, req0_ready}, 33'h0);
    sb_q.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("no_replay_after_rst", {32'h0, out_valid}, 33'h0);
    #1;
    // pointer back at RR_INIT=0, so requester 0 wins the tie
    cyc(1'b1, 32'h0000_0001, 5'd1, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 5'd1, 1'b1, 1'b0,
        1'b1, 1'b1, 1'b0, 32'h0000_0002);
    cyc(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("scoreboard_empty", 33'(sb_q.size()), 33'h0);
    chk("final_idle", {32'h0, out_valid}, 33'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_arb.md
SHIFT_ARB -- requirements
Module: shift_arb

Interface
REQ-001 The block SHALL have parameter RR_INIT, default 0, selecting the requester that holds priority after reset (0 or 1).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port req0_valid, input, 1 bit: requester 0 presents a shift operation.
REQ-005 The block SHALL have port req0_d, input, 32 bits: requester 0 operand.
REQ-006 The block SHALL have port req0_sa, input, 5 bits: requester 0 shift amount.
REQ-007 The block SHALL have port req0_right, input, 1 bit: requester 0 direction; 0 = left, 1 = right.
REQ-008 The block SHALL have port req0_arith, input, 1 bit: requester 0 right-shift type; 1 = arithmetic, 0 = logical.
REQ-009 The block SHALL have port req0_ready, output, 1 bit: requester 0 operation accepted this cycle.
REQ-010 The block SHALL have ports req1_valid, req1_d, req1_sa, req1_right, req1_arith and req1_ready, identical to REQ-004 to REQ-009 but serving requester 1.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_sh holds a result.
REQ-012 The block SHALL have port out_sh, output, 32 bits: registered shift result.
REQ-013 The block SHALL have port out_id, output, 1 bit: the requester that owns out_sh.
REQ-014 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result when out_valid is also 1.
REQ-015 The block SHALL have port busy, output, 1 bit: equal to out_valid, for the hazard logic.

Function
REQ-016 The block SHALL share one combinational shifter: right=0 gives d<<sa; right=1 with arith=0 gives d>>sa, zero fill; right=1 with arith=1 gives d>>>sa, sign fill. arith SHALL be ignored when right=0.
REQ-017 The block SHALL use states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-018 The block SHALL define can_accept = EMPTY, or FULL with out_ready=1 (same-cycle drain and refill).
REQ-019 The block SHALL grant at most one requester per cycle, and only when can_accept=1.
REQ-020 When exactly one requester is valid, the block SHALL grant that requester.
REQ-021 When both requesters are valid, the block SHALL grant the requester indicated by the priority pointer.
REQ-022 After each grant, the priority pointer SHALL point to the requester that was not granted (round-robin).
REQ-023 reqN_ready SHALL be a combinational function of the reqN_valid inputs, the state and out_ready, and SHALL be 1 only for the granted requester.
REQ-024 On a grant at edge N, out_sh SHALL load the shift of the granted operands, out_id SHALL load the granted index, and out_valid=1 from edge N onward: latency 1 cycle, throughput 1 per cycle.
REQ-025 In FULL with out_ready=0, out_sh, out_id and out_valid SHALL hold and both ready outputs SHALL be 0.
REQ-026 In FULL with out_ready=1 and no valid requester, the block SHALL go to EMPTY at the next edge.
REQ-027 A requester that is held off SHALL keep its operands stable while reqN_valid=1; the block SHALL sample operands only in the grant cycle.
REQ-028 sa=0 SHALL return d unchanged for all three modes.
REQ-029 A rising sa SHALL NOT cause wrap-around: sa is 5 bits, so the maximum shift is 31.

Reset
REQ-030 While rst=1, the block SHALL asynchronously force out_valid=0, busy=0, out_sh=32'h0, out_id=0, priority pointer=RR_INIT, and state EMPTY.
REQ-031 While rst=1, req0_ready and req1_ready SHALL be 0.
REQ-032 Assertion of rst SHALL abort the result held in FULL, and the block SHALL NOT re-present that result after reset.
REQ-033 The first grant SHALL be possible at the first rising edge after rst deasserts.

Verification
REQ-034 With RR_INIT=0, req0 only valid with d=32'h8000_0001, sa=4, right=1, arith=1, and out_ready=1 -> req0_ready=1; next cycle out_sh=32'hF800_0000, out_id=0.
REQ-035 Both requesters valid for 4 cycles with out_ready=1 -> grants are 0,1,0,1 and out_id follows one cycle later.
REQ-036 FULL with out_ready=0 for 3 cycles while both requesters are valid -> both ready=0, out_sh stable; when out_ready rises, the result drains and the next grant occurs in the same cycle.
REQ-037 req1 shifts d=32'h0000_00FF with sa=31, right=0 -> out_sh=32'h8000_0000; req1 shifts d=32'h8000_0000 with sa=31, right=1, arith=0 -> out_sh=32'h0000_0001.
REQ-038 rst pulsed asynchronously mid-cycle while FULL -> out_valid drops immediately without waiting for a clock edge, and the pointer returns to RR_INIT.
REQ-039 sa=0 in all three modes with d=32'hA5A5_A5A5 -> out_sh=32'hA5A5_A5A5.
